// File: rtl/cacheline_mem_arbiter.sv
// cacheline_mem_arbiter: shares one burst-memory port between icache and dcache line transfers.
// Index 0 is the icache requester, index 1 the dcache requester.
module cacheline_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_read,
  input  logic [ADDR_WIDTH-1:0]         i_addr,
  output logic [BEATS*BEAT_WIDTH-1:0]   i_rdata,
  output logic                          i_resp,
  input  logic                          d_read,
  input  logic                          d_write,
  input  logic [ADDR_WIDTH-1:0]         d_addr,
  input  logic [BEATS*BEAT_WIDTH-1:0]   d_wdata,
  output logic [BEATS*BEAT_WIDTH-1:0]   d_rdata,
  output logic                          d_resp,
  output logic [ADDR_WIDTH-1:0]         bmem_addr,
  output logic                          bmem_read,
  output logic                          bmem_write,
  output logic [BEAT_WIDTH-1:0]         bmem_wdata,
  input  logic                          bmem_ready,
  input  logic [ADDR_WIDTH-1:0]         bmem_raddr,
  input  logic [BEAT_WIDTH-1:0]         bmem_rdata,
  input  logic                          bmem_rvalid,
  output logic                          unexp_rvalid
);
  localparam int CW = $clog2(BEATS);
  localparam int LW = BEATS*BEAT_WIDTH;
  typedef enum logic [1:0] {IDLE, RD_ISSUE, WR_BEAT} state_t;
  state_t state;
  logic [1:0] pend, hit, done, req, elig;
  logic [ADDR_WIDTH-1:0] cap [2];
  logic [CW-1:0] cnt [2];
  logic [LW-1:0] lbuf [2];
  logic [LW-1:0] line [2];
  logic [CW-1:0] beat, nbeat;
  logic [ADDR_WIDTH-1:0] waddr;
  logic sel, ptr, win, wr, share, wr_resp;
  genvar r;
  generate
    for (r = 0; r < 2; r++) begin : g_rd
      assign hit[r]  = bmem_rvalid && pend[r] && cap[r] == bmem_raddr;
      assign done[r] = hit[r] && cnt[r] == CW'(BEATS-1);
      assign line[r] = done[r] ? {bmem_rdata, lbuf[r][LW-BEAT_WIDTH-1:0]} : lbuf[r];
    end
  endgenerate
  assign i_rdata = line[0];
  assign d_rdata = line[1];
  assign i_resp  = done[0];
  assign d_resp  = done[1] | wr_resp;
  // ptr set means the dcache has priority on the next tie
  always_comb begin
    req   = {d_read | d_write, i_read};
    elig  = req & ~pend & ~done & {~wr_resp, 1'b1};
    win   = elig[1] && (ptr || !elig[0]);
    waddr = win ? d_addr : i_addr;
    wr    = win && d_write;
    nbeat = beat + 1'b1;
    share = !wr && pend[!win] && !done[!win] && cap[!win] == waddr;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pend       <= '0;
      cap[0]     <= '0;
      cap[1]     <= '0;
      sel        <= 1'b0;
      ptr        <= 1'b1;
      beat       <= '0;
      wr_resp    <= 1'b0;
      bmem_addr  <= '0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
    end else begin
      wr_resp <= 1'b0;
      pend    <= pend & ~done;
      case (state)
        IDLE: if (|elig) begin
          ptr      <= !win;
          sel      <= win;
          cap[win] <= waddr;
          if (wr) begin
            bmem_write <= 1'b1;
            bmem_addr  <= d_addr;
            bmem_wdata <= d_wdata[BEAT_WIDTH-1:0];
            beat       <= '0;
            state      <= WR_BEAT;
          end else if (share) begin
            pend[win] <= 1'b1;
          end else begin
            bmem_read <= 1'b1;
            bmem_addr <= waddr;
            state     <= RD_ISSUE;
          end
        end
        RD_ISSUE: if (bmem_ready) begin
          bmem_read <= 1'b0;
          pend[sel] <= 1'b1;
          state     <= IDLE;
        end
        WR_BEAT: if (bmem_ready) begin
          if (beat == CW'(BEATS-1)) begin
            bmem_write <= 1'b0;
            wr_resp    <= 1'b1;
            state      <= IDLE;
          end else begin
            beat       <= nbeat;
            bmem_wdata <= d_wdata[nbeat*BEAT_WIDTH +: BEAT_WIDTH];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  // every pending reader whose address matches takes the beat, so shared reads fill together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        cnt[k]  <= '0;
        lbuf[k] <= '0;
      end
      unexp_rvalid <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++)
        if (hit[k]) begin
          lbuf[k][cnt[k]*BEAT_WIDTH +: BEAT_WIDTH] <= bmem_rdata;
          cnt[k] <= cnt[k] + 1'b1;
        end
      if (bmem_rvalid && !(|hit)) unexp_rvalid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// tb_cacheline_mem_arbiter: directed scoreboard bench for cacheline_mem_arbiter.
module tb_cacheline_mem_arbiter;
  localparam int AW = 32;
  localparam int BW = 64;
  localparam int LW = 256;
  typedef struct packed {logic wr; logic [LW-1:0] data;} dexp_t;
  logic clk = 1'b0;
  logic rst;
  logic i_read, i_resp, d_read, d_write, d_resp;
  logic [AW-1:0] i_addr, d_addr, bmem_addr, bmem_raddr;
  logic [LW-1:0] i_rdata, d_rdata, d_wdata;
  logic bmem_read, bmem_write, bmem_ready, bmem_rvalid, unexp_rvalid;
  logic [BW-1:0] bmem_wdata, bmem_rdata;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int wacc = 0;
  int wacc_cyc = -1;
  int i_cyc = -1;
  int d_cyc = -1;
  int last_cyc = -1;
  logic [AW-1:0] cq[$];
  logic [LW-1:0] iq[$];
  dexp_t dq[$];
  logic [BW-1:0] wq[$];
  logic [AW-1:0] wexp_addr;
  logic [LW-1:0] il, dl, wl;
  dexp_t e;

  cacheline_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .unexp_rvalid(unexp_rvalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] mk_line(input logic [7:0] s);
    logic [LW-1:0] l;
    for (int k = 0; k < 4; k++) l[k*BW +: BW] = {s, 24'h0, 24'hC0FFEE, 8'(k)};
    return l;
  endfunction

  // scoreboard side: pops expectations whenever the DUT commits a command, beat or response
  always @(negedge clk) begin
    if (!rst) begin
      if (bmem_read && bmem_ready) begin
        if (cq.size() == 0) chk("rd_cmd_spurious", {255'd0, bmem_read}, '0);
        else chk("rd_cmd_addr", {224'd0, bmem_addr}, {224'd0, cq.pop_front()});
      end
      if (bmem_write && bmem_ready) begin
        wacc     <= wacc + 1;
        wacc_cyc <= cyc;
        chk("wr_addr", {224'd0, bmem_addr}, {224'd0, wexp_addr});
        if (wq.size() == 0) chk("wr_spurious", {255'd0, bmem_write}, '0);
        else chk("wr_beat", {192'd0, bmem_wdata}, {192'd0, wq.pop_front()});
      end
      if (i_resp) begin
        i_cyc <= cyc;
        if (iq.size() == 0) chk("i_resp_spurious", {255'd0, i_resp}, '0);
        else chk("i_rdata", i_rdata, iq.pop_front());
      end
      if (d_resp) begin
        d_cyc <= cyc;
        if (dq.size() == 0) chk("d_resp_spurious", {255'd0, d_resp}, '0);
        else begin
          e = dq.pop_front();
          if (e.wr) chk("d_wr_resp_lat", LW'(cyc), LW'(wacc_cyc + 1));
          else chk("d_rdata", d_rdata, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic wait_cmds();
    for (int k = 0; k < 40 && cq.size() != 0; k++) step();
    chk("cmd_drain", LW'(cq.size()), '0);
  endtask

  task automatic burst(input logic [AW-1:0] a, input logic [LW-1:0] l);
    for (int k = 0; k < 4; k++) begin
      step();
      bmem_rvalid = 1'b1;
      bmem_raddr  = a;
      bmem_rdata  = l[k*BW +: BW];
      last_cyc    = cyc;
    end
    step();
    bmem_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    i_read = 0; d_read = 0; d_write = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    bmem_ready = 1'b1; bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
    wexp_addr = 32'h2000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bmem_read", {255'd0, bmem_read}, '0);
    chk("rst_bmem_write", {255'd0, bmem_write}, '0);
    chk("rst_bmem_addr", {224'd0, bmem_addr}, '0);
    chk("rst_bmem_wdata", {192'd0, bmem_wdata}, '0);
    chk("rst_resp", {254'd0, i_resp, d_resp}, '0);
    chk("rst_rdata", i_rdata | d_rdata, '0);
    chk("rst_unexp", {255'd0, unexp_rvalid}, '0);
    step();
    rst = 1'b0;
    // single icache read
    il = mk_line(8'h1A);
    cq.push_back(32'h1000);
    iq.push_back(il);
    i_addr = 32'h1000;
    i_read = 1'b1;
    wait_cmds();
    repeat (10) step();
    burst(32'h1000, il);
    i_read = 1'b0;
    chk("i_resp_cyc", LW'(i_cyc), LW'(last_cyc));
    // dcache write with a 3-cycle stall on beat 2
    wl = mk_line(8'h2B);
    for (int k = 0; k < 4; k++) wq.push_back(wl[k*BW +: BW]);
    dq.push_back({1'b1, 256'd0});
    d_addr = 32'h2000;
    d_wdata = wl;
    d_write = 1'b1;
    for (int k = 0; k < 40 && wacc < 2; k++) step();
    bmem_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("wr_hold_data", {192'd0, bmem_wdata}, {192'd0, wl[2*BW +: BW]});
    end
    step();
    bmem_ready = 1'b1;
    for (int k = 0; k < 20 && dq.size() != 0; k++) step();
    chk("d_wr_resp_seen", LW'(dq.size()), '0);
    d_write = 1'b0;
    repeat (3) step();
    chk("wr_beats", LW'(wacc), LW'(4));
    // simultaneous I/D reads, out-of-order return
    do_reset();
    il = mk_line(8'h3C);
    dl = mk_line(8'h4D);
    cq.push_back(32'h200);
    cq.push_back(32'h100);
    iq.push_back(il);
    dq.push_back({1'b0, dl});
    i_addr = 32'h100;
    d_addr = 32'h200;
    i_read = 1'b1;
    d_read = 1'b1;
    wait_cmds();
    repeat (2) step();
    burst(32'h200, dl);
    d_read = 1'b0;
    chk("d_resp_cyc", LW'(d_cyc), LW'(last_cyc));
    burst(32'h100, il);
    i_read = 1'b0;
    chk("i_resp_cyc2", LW'(i_cyc), LW'(last_cyc));
    // both requesters read the same line: one command, shared response
    il = mk_line(8'h5E);
    cq.push_back(32'h300);
    iq.push_back(il);
    dq.push_back({1'b0, il});
    i_addr = 32'h300;
    d_addr = 32'h300;
    i_read = 1'b1;
    d_read = 1'b1;
    wait_cmds();
    repeat (3) step();
    burst(32'h300, il);
    i_read = 1'b0;
    d_read = 1'b0;
    chk("shared_i_cyc", LW'(i_cyc), LW'(last_cyc));
    chk("shared_d_cyc", LW'(d_cyc), LW'(last_cyc));
    chk("unexp_clean", {255'd0, unexp_rvalid}, '0);
    // stray beat with nothing pending
    step();
    bmem_rvalid = 1'b1;
    bmem_raddr = 32'hDEAD_0000;
    bmem_rdata = 64'h1234_5678_9ABC_DEF0;
    step();
    bmem_rvalid = 1'b0;
    @(negedge clk);
    chk("unexp_set", {255'd0, unexp_rvalid}, {255'd0, 1'b1});
    repeat (5) step();
    @(negedge clk);
    chk("unexp_sticky", {255'd0, unexp_rvalid}, {255'd0, 1'b1});
    // reset with a read in flight, then the stale burst arrives
    il = mk_line(8'h6F);
    cq.push_back(32'h400);
    i_addr = 32'h400;
    i_read = 1'b1;
    wait_cmds();
    repeat (2) step();
    i_read = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rst_unexp_clr", {255'd0, unexp_rvalid}, '0);
    step();
    burst(32'h400, il);
    @(negedge clk);
    chk("stale_unexp", {255'd0, unexp_rvalid}, {255'd0, 1'b1});
    // normal operation resumes after reset
    step();
    dl = mk_line(8'h70);
    cq.push_back(32'h500);
    dq.push_back({1'b0, dl});
    d_addr = 32'h500;
    d_read = 1'b1;
    wait_cmds();
    repeat (2) step();
    burst(32'h500, dl);
    d_read = 1'b0;
    chk("post_rst_d_cyc", LW'(d_cyc), LW'(last_cyc));
    repeat (3) step();
    chk("iq_empty", LW'(iq.size()), '0);
    chk("dq_empty", LW'(dq.size()), '0);
    chk("wq_empty", LW'(wq.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cacheline_mem_arbiter.md
Name: cacheline_mem_arbiter

Overview:
- Shares the single banked burst-memory port (bmem_*) between the instruction cache (read-only) and the data cache (read/write).
- Each requester works with 256-bit lines. The block splits each line into four 64-bit bursts, issues at most one memory command per cycle, and reassembles read bursts.
- Read data may return out of order across requesters. Returned bursts are routed to requesters by matching bmem_raddr.
- Sits between the caches and the cpu top-level bmem ports.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- BEAT_WIDTH, 64, bmem data width per burst beat.
- BEATS, 4, beats per cache line (line width = BEATS*BEAT_WIDTH).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_read  in  1  icache line read request, held until i_resp
- i_addr  in  ADDR_WIDTH  icache line address, 32-byte aligned
- i_rdata  out  BEATS*BEAT_WIDTH  icache line data, valid with i_resp
- i_resp  out  1  one-cycle completion pulse
- d_read  in  1  dcache line read request, held until d_resp
- d_write  in  1  dcache line write request, held until d_resp; never asserted together with d_read
- d_addr  in  ADDR_WIDTH  dcache line address, aligned
- d_wdata  in  BEATS*BEAT_WIDTH  write line data, beat 0 = bits [63:0]
- d_rdata  out  BEATS*BEAT_WIDTH  dcache read line data
- d_resp  out  1  one-cycle completion pulse
- bmem_addr  out  ADDR_WIDTH  command address
- bmem_read  out  1  read command
- bmem_write  out  1  write beat
- bmem_wdata  out  BEAT_WIDTH  write beat data
- bmem_ready  in  1  memory accepts a command or beat this cycle
- bmem_raddr  in  ADDR_WIDTH  address of the returning read burst
- bmem_rdata  in  BEAT_WIDTH  read beat data
- bmem_rvalid  in  1  read beat valid
- unexp_rvalid  out  1  sticky: an rvalid beat matched no pending read

Behaviour:
- Reset (asynchronous) clears all state. Outputs after reset: bmem_read/write=0, bmem_addr/wdata=0, i_resp/d_resp=0, i_rdata/d_rdata=0, unexp_rvalid=0, FSM=IDLE, grant pointer=D.
- Each requester has a pending flag, a captured address, a beat counter (2 bits) and a line buffer. At most one outstanding read per requester.
- A request is eligible when its input is high, it is not pending, and no response pulse is being emitted for it this cycle.
- Issue FSM states:
  - IDLE: choose among eligible requests round-robin. The winner is the requester not granted last; with one eligible, it wins. Go to RD_ISSUE or WR_BEAT with beat=0.
  - RD_ISSUE: drive bmem_read=1 and bmem_addr. When bmem_ready=1, set the requester's pending flag and return to IDLE. Otherwise hold.
  - WR_BEAT: drive bmem_write=1, bmem_addr=d_addr, bmem_wdata=beat slice. Advance beat on bmem_ready=1. Low ready holds the same beat.
  - After beat 3 is accepted: pulse d_resp the next cycle, return to IDLE.
- A read whose address equals the other requester's pending address is marked pending without issuing a command.
- Response collection runs concurrently with the FSM:
  - Each rvalid beat is written into the buffer of every pending reader whose captured address equals bmem_raddr, at index beat counter, and that counter increments.
  - When a counter wraps from 3 to 0: rdata is presented combinationally from the buffer with beat 3 bypassed, resp pulses that cycle, and pending clears.
  - A beat matching no pending reader is dropped and sets unexp_rvalid.
- Bursts from memory are 4 contiguous rvalid cycles. Interleaving between bursts is allowed.
- Latency:
  - A read command is accepted no earlier than 1 cycle after the request rises.
  - i_resp/d_resp fire in the same cycle as the 4th rvalid.
  - A write's resp fires 1 cycle after the 4th accepted beat.
- Simultaneous events: a beat return and a command issue in the same cycle are independent. A new request of the same requester is not eligible in its resp cycle.
- Reset mid-burst abandons all pending state. Later stale beats set unexp_rvalid.

Test Plan:
- Single I read at 0x0000_1000, memory returns beats A0..A3 after 10 cycles -> one bmem_read with addr 0x1000, i_resp on the A3 cycle, i_rdata = {A3,A2,A1,A0}.
- D write to 0x2000 with bmem_ready low on beat 2 for 3 cycles -> 4 accepted beats in order, with beat 2 data held stable. d_resp occurs exactly once, 1 cycle after beat 3.
- I read 0x100 and D read 0x200 requested together -> D issued first (reset pointer), then I. Memory returns 0x200 data before 0x100 -> d_resp before i_resp, with correct data each.
- I and D both read 0x300 -> exactly one bmem_read; i_resp and d_resp fire on the same cycle with identical data.
- rvalid with raddr 0xDEAD_0000 and nothing pending -> beat dropped, unexp_rvalid=1 and stays 1 until reset.
- Assert rst during an in-flight read, then memory returns its burst -> no resp pulse, unexp_rvalid=1, and the FSM accepts a new request normally.
